enemy_wave_ctrl: RTL

Scheduler for the NUM_ENEMY enemy tank instances.
- Generates per-tank move and fire commands each frame.
- Sequences death, respawn delay and reserve accounting.
- Arbitrates respawn so at most one enemy re-enters per frame.
- Sits at top level beside the enemy tank instances. It consumes their blocked, got_hit and bullet_active outputs and drives their move_*, fire and dead inputs.

---
 rtl/tank_pkg.sv | 43 ++++
 rtl/lfsr16.sv | 20 ++
 rtl/enemy_wave_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/tank_pkg.sv
// Shared tank types: one-hot direction encodings, enemy slot states and
// direction helpers used by the enemy scheduler.
package tank_pkg;

    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        WAIT   = 2'd1,
        OUT    = 2'd2
    } slot_state_e;

    // 00 UP, 01 DOWN, 10 LEFT, 11 RIGHT
    function automatic logic [3:0] dir_from_bits(input logic [1:0] bits);
        logic [3:0] d;
        case (bits)
            2'b00:   d = DIR_UP;
            2'b01:   d = DIR_DOWN;
            2'b10:   d = DIR_LEFT;
            default: d = DIR_RIGHT;
        endcase
        return d;
    endfunction

    // Steer along the axis with the larger distance to the target; ties go vertical.
    function automatic logic [3:0] aim_dir(input logic [9:0] px, input logic [9:0] py,
                                           input logic [9:0] ex, input logic [9:0] ey);
        logic [9:0] adx;
        logic [9:0] ady;
        logic [3:0] d;
        adx = (px >= ex) ? (px - ex) : (ex - px);
        ady = (py >= ey) ? (py - ey) : (ey - py);
        if (adx > ady)
            d = (px > ex) ? DIR_RIGHT : DIR_LEFT;
        else
            d = (py > ey) ? DIR_DOWN : DIR_UP;
        return d;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), advances once per enabled clock.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic        en,
    output logic [15:0] q
);

    localparam logic [15:0] TAPS = 16'hB400;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset)
            q <= SEED;
        else if (en)
            q <= (q >> 1) ^ (q[0] ? TAPS : 16'h0000);
    end

endmodule

// File: rtl/enemy_wave_ctrl.sv
// Enemy wave scheduler: per-slot move/fire commands, death/respawn sequencing
// and reserve accounting. Define ENEMY_AIM_EN to let tanks steer toward the player.
module enemy_wave_ctrl
    import tank_pkg::*;
#(
    parameter int unsigned NUM_ENEMY      = 3,
    parameter int unsigned TOTAL_ENEMIES  = 20,
    parameter int unsigned RESPAWN_FRAMES = 120,
    parameter int unsigned MIN_HOLD       = 16,
    parameter int unsigned FIRE_COOLDOWN  = 45,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                    frame_clk,
    input  logic                    Reset,
    input  logic                    game_active,
    input  logic [NUM_ENEMY-1:0]    blocked,
    input  logic [NUM_ENEMY-1:0]    got_hit,
    input  logic [NUM_ENEMY-1:0]    bullet_active,
    input  logic [9:0]              player_x,
    input  logic [9:0]              player_y,
    input  logic [NUM_ENEMY*10-1:0] enemy_x,
    input  logic [NUM_ENEMY*10-1:0] enemy_y,
    output logic [NUM_ENEMY-1:0]    move_up,
    output logic [NUM_ENEMY-1:0]    move_down,
    output logic [NUM_ENEMY-1:0]    move_left,
    output logic [NUM_ENEMY-1:0]    move_right,
    output logic [NUM_ENEMY-1:0]    fire,
    output logic [NUM_ENEMY-1:0]    dead,
    output logic [5:0]              enemies_left,
    output logic                    wave_clear
);

    localparam int unsigned TIMER_W = $clog2(RESPAWN_FRAMES + 1);
    localparam int unsigned HOLD_W  = $clog2(MIN_HOLD + 16);
    localparam int unsigned CD_W    = $clog2(FIRE_COOLDOWN + 1);
    localparam int unsigned IDX_W   = $clog2(NUM_ENEMY);
    localparam int unsigned CNT_W   = 6;

    slot_state_e          st_q    [NUM_ENEMY];
    slot_state_e          st_d    [NUM_ENEMY];
    logic [3:0]           dir_q   [NUM_ENEMY];
    logic [3:0]           dir_d   [NUM_ENEMY];
    logic [HOLD_W-1:0]    hold_q  [NUM_ENEMY];
    logic [HOLD_W-1:0]    hold_d  [NUM_ENEMY];
    logic [CD_W-1:0]      cd_q    [NUM_ENEMY];
    logic [CD_W-1:0]      cd_d    [NUM_ENEMY];
    logic [TIMER_W-1:0]   timer_q [NUM_ENEMY];
    logic [TIMER_W-1:0]   timer_d [NUM_ENEMY];

    logic [CNT_W-1:0]     reserve_q, reserve_d;
    logic [CNT_W-1:0]     left_d;
    logic [CNT_W-1:0]     alive_cnt;
    logic [IDX_W-1:0]     last_q, last_d;

    logic [NUM_ENEMY-1:0] mv_up_d, mv_down_d, mv_left_d, mv_right_d;
    logic [NUM_ENEMY-1:0] fire_d, dead_d;
    logic                 wave_d;

    logic [NUM_ENEMY-1:0] cand;
    logic                 grant_vld;
    logic                 grant_en;
    logic [IDX_W-1:0]     grant_idx;
    logic [15:0]          lfsr_q;
    logic                 unused_inputs;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .en        (game_active),
        .q         (lfsr_q)
    );

    // Aim inputs only feed logic when ENEMY_AIM_EN is defined.
    assign unused_inputs = ^{player_x, player_y, enemy_x, enemy_y, lfsr_q};

    // Respawn candidates and round-robin pick starting after the last grant.
    always_comb begin
        int unsigned j;
        j         = 0;
        cand      = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_ENEMY; i++)
            cand[i] = (st_q[i] == WAIT) && (timer_q[i] == '0);
        for (int unsigned k = 1; k <= NUM_ENEMY; k++) begin
            j = 32'(last_q) + k;
            if (j >= NUM_ENEMY)
                j = j - NUM_ENEMY;
            if (!grant_vld && cand[IDX_W'(j)]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

    assign grant_en = grant_vld && (reserve_q != '0);

    // Slot sequencing, movement, fire and wave accounting.
    always_comb begin
        for (int i = 0; i < NUM_ENEMY; i++) begin
            st_d[i]    = st_q[i];
            dir_d[i]   = dir_q[i];
            hold_d[i]  = hold_q[i];
            cd_d[i]    = cd_q[i];
            timer_d[i] = timer_q[i];
        end
        reserve_d  = reserve_q;
        last_d     = last_q;
        mv_up_d    = '0;
        mv_down_d  = '0;
        mv_left_d  = '0;
        mv_right_d = '0;
        fire_d     = '0;
        dead_d     = dead;
        wave_d     = 1'b0;
        left_d     = enemies_left;
        alive_cnt  = '0;

        if (game_active) begin
            for (int i = 0; i < NUM_ENEMY; i++) begin
                case (st_q[i])
                    ACTIVE: begin
                        if (got_hit[i]) begin
                            st_d[i]    = WAIT;
                            timer_d[i] = TIMER_W'(RESPAWN_FRAMES);
                        end else begin
                            if (blocked[i] || (hold_q[i] == '0)) begin
`ifdef ENEMY_AIM_EN
                                if (lfsr_q[15])
                                    dir_d[i] = aim_dir(player_x, player_y,
                                                       enemy_x[10*i +: 10], enemy_y[10*i +: 10]);
                                else
                                    dir_d[i] = dir_from_bits(lfsr_q[2*i +: 2]);
`else
                                dir_d[i] = dir_from_bits(lfsr_q[2*i +: 2]);
`endif
                                hold_d[i] = HOLD_W'(MIN_HOLD) + HOLD_W'(lfsr_q[11:8]);
                            end else begin
                                hold_d[i] = hold_q[i] - HOLD_W'(1);
                            end
                            if (cd_q[i] != '0) begin
                                cd_d[i] = cd_q[i] - CD_W'(1);
                            end else if (!bullet_active[i]) begin
                                fire_d[i] = 1'b1;
                                cd_d[i]   = CD_W'(FIRE_COOLDOWN);
                            end
                        end
                    end
                    WAIT: begin
                        if (timer_q[i] != '0) begin
                            timer_d[i] = timer_q[i] - TIMER_W'(1);
                        end else if (reserve_q == '0) begin
                            st_d[i] = OUT;
                        end else if (grant_en && (grant_idx == IDX_W'(i))) begin
                            st_d[i]   = ACTIVE;
                            hold_d[i] = HOLD_W'(MIN_HOLD);
                            cd_d[i]   = CD_W'(FIRE_COOLDOWN);
                        end
                    end
                    default: ;
                endcase

                if (st_d[i] == ACTIVE) begin
                    mv_up_d[i]    = dir_d[i][0];
                    mv_down_d[i]  = dir_d[i][1];
                    mv_left_d[i]  = dir_d[i][2];
                    mv_right_d[i] = dir_d[i][3];
                end
                dead_d[i] = (st_d[i] != ACTIVE);
                if (st_d[i] != OUT)
                    alive_cnt = alive_cnt + CNT_W'(1);
            end

            if (grant_en) begin
                reserve_d = reserve_q - CNT_W'(1);
                last_d    = grant_idx;
            end
            left_d = reserve_d + alive_cnt;
            wave_d = (enemies_left != '0) && (left_d == '0);
        end
    end

    // State and registered outputs.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_ENEMY; i++) begin
                st_q[i]    <= ACTIVE;
                dir_q[i]   <= DIR_UP;
                hold_q[i]  <= HOLD_W'(MIN_HOLD);
                cd_q[i]    <= CD_W'(FIRE_COOLDOWN);
                timer_q[i] <= '0;
            end
            reserve_q    <= CNT_W'(TOTAL_ENEMIES - NUM_ENEMY);
            last_q       <= IDX_W'(NUM_ENEMY - 1);
            move_up      <= '0;
            move_down    <= '0;
            move_left    <= '0;
            move_right   <= '0;
            fire         <= '0;
            dead         <= '0;
            enemies_left <= CNT_W'(TOTAL_ENEMIES);
            wave_clear   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ENEMY; i++) begin
                st_q[i]    <= st_d[i];
                dir_q[i]   <= dir_d[i];
                hold_q[i]  <= hold_d[i];
                cd_q[i]    <= cd_d[i];
                timer_q[i] <= timer_d[i];
            end
            reserve_q    <= reserve_d;
            last_q       <= last_d;
            move_up      <= mv_up_d;
            move_down    <= mv_down_d;
            move_left    <= mv_left_d;
            move_right   <= mv_right_d;
            fire         <= fire_d;
            dead         <= dead_d;
            enemies_left <= left_d;
            wave_clear   <= wave_d;
        end
    end

endmodule
